keypad_dispenser: RTL and testbench

One-time-pad key source that feeds the key input of the brickwall cipher stage. It holds a bounded pad of 32-bit keys and issues each key exactly once, one per sealed 32-bit plaintext word. Every consumed entry is zeroized, and loading closes once dispensing starts. When the pad runs out, the block reports exhaustion so the encrypt path aborts instead of reusing key material.

---
 rtl/keypad_dispenser.sv | 108 ++++++++++
 tb/tb_keypad_dispenser.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_dispenser.sv
// One-time-pad key source: stores a bounded pad of keys, hands each out exactly once,
// zeroizes every consumed entry and reports exhaustion instead of reusing material.
module keypad_dispenser #(
    parameter int KEY_W = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [KEY_W-1:0] load_key,
    output logic             load_ready,
    output logic             load_drop,
    input  logic             key_take,
    output logic             key_valid,
    output logic [KEY_W-1:0] key_out,
    output logic [AW:0]      keys_left,
    output logic             exhausted,
    output logic             wiping,
    input  logic             pad_clear
);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        DISPENSE,
        EXHAUSTED,
        WIPE
    } state_e;

    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_e           state_q;
    logic [KEY_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wipe_cnt_q;
    logic [AW:0]      keys_left_q;
    logic [AW:0]      keys_left_d;
    logic             load_drop_q;
    logic             do_load;
    logic             do_take;
    logic             drop_d;

    always_comb begin
        load_ready  = (state_q == IDLE || state_q == ARMED) && (keys_left_q < FULL);
        key_valid   = (keys_left_q != '0) && (state_q == ARMED || state_q == DISPENSE);
        key_out     = key_valid ? mem_q[rd_ptr_q] : '0;
        do_load     = load_valid && load_ready && (load_key != '0);
        do_take     = key_take && key_valid;
        drop_d      = load_valid && ((load_key == '0) || !load_ready);
        keys_left_d = keys_left_q + (AW+1)'(do_load) - (AW+1)'(do_take);
    end

    assign keys_left = keys_left_q;
    assign load_drop = load_drop_q;
    assign exhausted = (state_q == EXHAUSTED);
    assign wiping    = (state_q == WIPE);

    // pad_clear outranks any same-cycle load or take; the wipe sweep itself cannot be restarted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            wipe_cnt_q  <= '0;
            keys_left_q <= '0;
            load_drop_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            load_drop_q <= drop_d;
            if (pad_clear && state_q != WIPE) begin
                state_q     <= WIPE;
                wipe_cnt_q  <= '0;
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                keys_left_q <= '0;
            end else if (state_q == WIPE) begin
                mem_q[wipe_cnt_q] <= '0;
                wipe_cnt_q        <= wipe_cnt_q + AW'(1);
                if (wipe_cnt_q == LAST) begin
                    state_q <= IDLE;
                end
            end else begin
                if (do_load) begin
                    mem_q[wr_ptr_q] <= load_key;
                    wr_ptr_q        <= wr_ptr_q + AW'(1);
                end
                if (do_take) begin
                    mem_q[rd_ptr_q] <= '0;
                    rd_ptr_q        <= rd_ptr_q + AW'(1);
                end
                keys_left_q <= keys_left_d;
                // A single-key pad can go straight from ARMED to EXHAUSTED on its only take.
                case (state_q)
                    IDLE:     if (do_load) state_q <= ARMED;
                    ARMED:    if (do_take) state_q <= (keys_left_d == '0) ? EXHAUSTED : DISPENSE;
                    DISPENSE: if (do_take && keys_left_d == '0) state_q <= EXHAUSTED;
                    default:  ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_dispenser.sv
// Directed self-checking bench for keypad_dispenser: load/take ordering, refusals,
// exhaustion, full-pad wrap, wipe duration with zeroization, and async reset.
module tb_keypad_dispenser;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load_valid = 1'b0;
    logic [31:0] load_key = '0;
    logic        load_ready;
    logic        load_drop;
    logic        key_take = 1'b0;
    logic        key_valid;
    logic [31:0] key_out;
    logic [4:0]  keys_left;
    logic        exhausted;
    logic        wiping;
    logic        pad_clear = 1'b0;

    int checks = 0;
    int errors = 0;

    keypad_dispenser #(.KEY_W(32), .DEPTH(16), .AW(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_key   (load_key),
        .load_ready (load_ready),
        .load_drop  (load_drop),
        .key_take   (key_take),
        .key_valid  (key_valid),
        .key_out    (key_out),
        .keys_left  (keys_left),
        .exhausted  (exhausted),
        .wiping     (wiping),
        .pad_clear  (pad_clear)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic lv, input logic [31:0] lk, input logic tk, input logic pc);
        load_valid = lv;
        load_key   = lk;
        key_take   = tk;
        pad_clear  = pc;
        tick();
        load_valid = 1'b0;
        load_key   = '0;
        key_take   = 1'b0;
        pad_clear  = 1'b0;
    endtask

    task automatic wipeAndWait(output int cycles);
        int guard;
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        cycles = wiping ? 1 : 0;
        guard  = 0;
        while (wiping && guard < 40) begin
            tick();
            if (wiping) cycles++;
            guard++;
        end
    endtask

    logic [31:0] fillKeys [16];
    int          wipeCycles;
    logic [31:0] memOr;

    initial begin
        $display("[TB] start");
        #2;
        checkOutput("rst_key_valid", 32'(key_valid), 32'd0);
        checkOutput("rst_key_out", key_out, 32'd0);
        checkOutput("rst_load_ready", 32'(load_ready), 32'd1);
        checkOutput("rst_load_drop", 32'(load_drop), 32'd0);
        checkOutput("rst_exhausted", 32'(exhausted), 32'd0);
        checkOutput("rst_wiping", 32'(wiping), 32'd0);
        checkOutput("rst_keys_left", 32'(keys_left), 32'd0);
        #10 reset = 1'b1;

        applyStimulus(1'b1, 32'hA5A5A5A5, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0F0F0F0F, 1'b0, 1'b0);
        checkOutput("armed_keys_left", 32'(keys_left), 32'd2);
        checkOutput("armed_key_valid", 32'(key_valid), 32'd1);
        checkOutput("armed_key_out", key_out, 32'hA5A5A5A5);
        checkOutput("armed_load_ready", 32'(load_ready), 32'd1);

        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("take1_key_out", key_out, 32'h0F0F0F0F);
        checkOutput("take1_keys_left", 32'(keys_left), 32'd1);
        checkOutput("dispense_load_ready", 32'(load_ready), 32'd0);
        applyStimulus(1'b1, 32'h11111111, 1'b0, 1'b0);
        checkOutput("dispense_load_drop", 32'(load_drop), 32'd1);
        checkOutput("dispense_keys_left", 32'(keys_left), 32'd1);
        tick();
        checkOutput("drop_is_pulse", 32'(load_drop), 32'd0);
        checkOutput("dispense_key_out", key_out, 32'h0F0F0F0F);

        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("final_exhausted", 32'(exhausted), 32'd1);
        checkOutput("final_key_valid", 32'(key_valid), 32'd0);
        checkOutput("final_key_out", key_out, 32'd0);
        key_take = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        key_take = 1'b0;
        checkOutput("held_take_keys_left", 32'(keys_left), 32'd0);
        checkOutput("held_take_exhausted", 32'(exhausted), 32'd1);
        checkOutput("held_take_key_out", key_out, 32'd0);

        wipeAndWait(wipeCycles);
        checkOutput("wipe1_cycles", 32'(wipeCycles), 32'd16);
        checkOutput("wipe1_load_ready", 32'(load_ready), 32'd1);
        checkOutput("wipe1_exhausted", 32'(exhausted), 32'd0);

        for (int i = 0; i < 16; i++) begin
            fillKeys[i] = 32'h10000001 + 32'(i) * 32'h01010101;
            applyStimulus(1'b1, fillKeys[i], 1'b0, 1'b0);
        end
        checkOutput("full_keys_left", 32'(keys_left), 32'd16);
        checkOutput("full_load_ready", 32'(load_ready), 32'd0);
        applyStimulus(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        checkOutput("full_load_drop", 32'(load_drop), 32'd1);
        checkOutput("full_keys_left_kept", 32'(keys_left), 32'd16);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("order_key_%0d", i), key_out, fillKeys[i]);
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
        end
        checkOutput("drain_exhausted", 32'(exhausted), 32'd1);
        checkOutput("drain_key_out", key_out, 32'd0);

        wipeAndWait(wipeCycles);
        applyStimulus(1'b1, 32'h00000000, 1'b0, 1'b0);
        checkOutput("zero_load_drop", 32'(load_drop), 32'd1);
        checkOutput("zero_keys_left", 32'(keys_left), 32'd0);
        checkOutput("zero_key_valid", 32'(key_valid), 32'd0);
        checkOutput("zero_load_ready", 32'(load_ready), 32'd1);

        applyStimulus(1'b1, 32'hB1B1B1B1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hB2B2B2B2, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hB3B3B3B3, 1'b1, 1'b0);
        checkOutput("ldtake_keys_left", 32'(keys_left), 32'd2);
        checkOutput("ldtake_key_out", key_out, 32'hB2B2B2B2);
        checkOutput("ldtake_load_ready", 32'(load_ready), 32'd0);

        wipeAndWait(wipeCycles);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'hC0000000 + 32'(i + 1), 1'b0, 1'b0);
        checkOutput("five_keys_left", 32'(keys_left), 32'd5);
        checkOutput("five_key_out", key_out, 32'hC0000001);
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checkOutput("clear_wiping", 32'(wiping), 32'd1);
        checkOutput("clear_key_valid", 32'(key_valid), 32'd0);
        wipeCycles = 1;
        for (int g = 0; g < 40 && wiping; g++) begin
            tick();
            if (wiping) wipeCycles++;
        end
        checkOutput("clear_wipe_cycles", 32'(wipeCycles), 32'd16);
        checkOutput("clear_keys_left", 32'(keys_left), 32'd0);
        checkOutput("clear_load_ready", 32'(load_ready), 32'd1);
        memOr = '0;
        for (int i = 0; i < 16; i++) memOr |= dut.mem_q[i];
        checkOutput("clear_mem_zero", memOr, 32'd0);

        applyStimulus(1'b1, 32'hE1E1E1E1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hE2E2E2E2, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("midwipe_wiping", 32'(wiping), 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("async_rst_wiping", 32'(wiping), 32'd0);
        checkOutput("async_rst_load_ready", 32'(load_ready), 32'd1);
        checkOutput("async_rst_keys_left", 32'(keys_left), 32'd0);
        checkOutput("async_rst_key_valid", 32'(key_valid), 32'd0);
        checkOutput("async_rst_load_drop", 32'(load_drop), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
